// File: rtl/aig_truth_sweeper.sv
// Exhaustive sequential evaluator for a combinational AIG: drives every input
// vector, captures the realised truth table and compares it with a golden table.
module aig_truth_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      dut_x,
  input  logic                 dut_z,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   truth_table,
  output logic [N_IN:0]        mismatch_count,
  output logic [N_IN-1:0]      first_fail_idx
);

  localparam int T  = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN:0] IDX_LAST = (N_IN + 1)'(T - 1);
  localparam logic [N_IN:0] IDX_ONE  = (N_IN + 1)'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_r, state_nx_s;
  logic [N_IN:0]   idx_r, idx_nx_s;
  logic [CW-1:0]   cnt_r, cnt_nx_s;
  logic            drive_nx_s;
  logic            mismatch_s;
  logic [T-1:0]    exp_r, tt_r;
  logic [N_IN:0]   mm_r;
  logic [N_IN-1:0] ff_r, dut_x_r;
  logic            busy_r, done_r, pass_r;

  assign dut_x          = dut_x_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign truth_table    = tt_r;
  assign mismatch_count = mm_r;
  assign first_fail_idx = ff_r;

  // Next-state, vector index and settle-count logic
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_DRIVE;
          idx_nx_s   = {(N_IN + 1){1'b0}};
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = ST_SAMPLE;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      ST_SAMPLE: begin
        // terminal compare on T-1 keeps idx from ever wrapping
        if (idx_r == IDX_LAST) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DRIVE;
          idx_nx_s   = idx_r + IDX_ONE;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
        idx_nx_s   = {(N_IN + 1){1'b0}};
      end
      default: begin
        state_nx_s = ST_IDLE;
        idx_nx_s   = {(N_IN + 1){1'b0}};
        cnt_nx_s   = {CW{1'b0}};
      end
    endcase
  end

  // Vector is on the AIG inputs throughout DRIVE and SAMPLE
  always_comb begin
    drive_nx_s = 1'b0;
    if ((state_nx_s == ST_DRIVE) || (state_nx_s == ST_SAMPLE)) begin
      drive_nx_s = 1'b1;
    end else begin
      drive_nx_s = 1'b0;
    end
  end

  assign mismatch_s = (dut_z != exp_r[idx_r[N_IN-1:0]]);

  // State register and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= {(N_IN + 1){1'b0}};
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dut_x_r <= {N_IN{1'b0}};
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
      cnt_r   <= cnt_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      done_r  <= (state_nx_s == ST_DONE);
      dut_x_r <= drive_nx_s ? idx_nx_s[N_IN-1:0] : {N_IN{1'b0}};
    end
  end

  // Golden-table latch and result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_r  <= {T{1'b0}};
      tt_r   <= {T{1'b0}};
      mm_r   <= {(N_IN + 1){1'b0}};
      ff_r   <= {N_IN{1'b0}};
      pass_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            exp_r  <= expected;
            tt_r   <= {T{1'b0}};
            mm_r   <= {(N_IN + 1){1'b0}};
            ff_r   <= {N_IN{1'b0}};
            pass_r <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          tt_r[idx_r[N_IN-1:0]] <= dut_z;
          if (mismatch_s) begin
            mm_r <= mm_r + IDX_ONE;
            if (mm_r == {(N_IN + 1){1'b0}}) begin
              ff_r <= idx_r[N_IN-1:0];
            end
          end
        end
        ST_DONE: begin
          pass_r <= (mm_r == {(N_IN + 1){1'b0}});
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aig_truth_sweeper.sv
// Directed bench: two sweepers (SETTLE=1 and SETTLE=3) driving small AIG models.
module tb_aig_truth_sweeper;

  logic       clk = 1'b0;
  logic       rst, start1, start3;
  logic [7:0] expected;
  logic [2:0] dut_x1, dut_x3;
  logic       dut_z1, dut_z3;
  logic       busy1, busy3, done1, done3, pass1, pass3;
  logic [7:0] tt1, tt3;
  logic [3:0] mm1, mm3;
  logic [2:0] ff1, ff3;
  logic       d1_1, d2_1, d1_3, d2_3;
  int         mode1, mode3;
  int         n_err = 0;
  int         n_chk = 0;

  always #5 clk = ~clk;

  aig_truth_sweeper #(.N_IN(3), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .expected(expected),
    .dut_x(dut_x1), .dut_z(dut_z1), .busy(busy1), .done(done1), .pass(pass1),
    .truth_table(tt1), .mismatch_count(mm1), .first_fail_idx(ff1));

  aig_truth_sweeper #(.N_IN(3), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .expected(expected),
    .dut_x(dut_x3), .dut_z(dut_z3), .busy(busy3), .done(done3), .pass(pass3),
    .truth_table(tt3), .mismatch_count(mm3), .first_fail_idx(ff3));

  // modes: 0 AND3, 1 XOR3, 2 const 0, 3 AND3 delayed by two registers
  function automatic logic aig(input int m, input logic [2:0] x, input logic dly);
    case (m)
      0:       return &x;
      1:       return ^x;
      2:       return 1'b0;
      default: return dly;
    endcase
  endfunction

  assign dut_z1 = aig(mode1, dut_x1, d2_1);
  assign dut_z3 = aig(mode3, dut_x3, d2_3);

  always @(posedge clk) begin
    d1_1 <= &dut_x1;
    d2_1 <= d1_1;
    d1_3 <= &dut_x3;
    d2_3 <= d1_3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sweep: start pulse in cycle 0, run to done_cyc+1, checking done timing
  task automatic run(input int sel, input int m, input logic [7:0] exp,
                     input int done_cyc, input bit chk_x, input bit disturb);
    int   ndone;
    int   first;
    logic dn, bz;
    logic [2:0] x;
    ndone = 0;
    first = -1;
    @(negedge clk);
    if (sel == 1) begin mode3 = m; start3 = 1'b1; end
    else          begin mode1 = m; start1 = 1'b1; end
    expected = exp;
    for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
      if (disturb && cyc == 5) begin
        start1   = 1'b1;
        expected = 8'h00;
      end
      dn = (sel == 1) ? done3 : done1;
      bz = (sel == 1) ? busy3 : busy1;
      x  = (sel == 1) ? dut_x3 : dut_x1;
      if (dn) begin
        ndone++;
        if (first < 0) first = cyc;
      end
      if (cyc == 1)            chk("busy_first", {31'd0, bz}, 32'd1);
      if (cyc == done_cyc)     chk("busy_done", {31'd0, bz}, 32'd1);
      if (cyc == done_cyc + 1) chk("busy_after", {31'd0, bz}, 32'd0);
      if (chk_x && cyc < done_cyc) chk("dut_x_step", {29'd0, x}, (cyc - 1) / 2);
      if (chk_x && cyc == done_cyc) chk("dut_x_done", {29'd0, x}, 32'd0);
    end
    chk("done_count", ndone, 32'd1);
    chk("done_cycle", first, done_cyc);
  endtask

  initial begin
    int ndone;
    int dc[2];
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; expected = 8'h00;
    mode1 = 0; mode3 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dut_x", {29'd0, dut_x1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    chk("rst_pass", {31'd0, pass1}, 32'd0);
    chk("rst_tt", {24'd0, tt1}, 32'd0);
    chk("rst_mm", {28'd0, mm1}, 32'd0);
    chk("rst_ff", {29'd0, ff1}, 32'd0);
    chk("rst_busy3", {31'd0, busy3}, 32'd0);

    // AND3 against its own table
    run(0, 0, 8'h80, 17, 1'b1, 1'b0);
    chk("and_tt", {24'd0, tt1}, 32'h80);
    chk("and_mm", {28'd0, mm1}, 32'd0);
    chk("and_pass", {31'd0, pass1}, 32'd1);

    // XOR3 against a table differing in bit 0
    run(0, 1, 8'h97, 17, 1'b0, 1'b0);
    chk("xor_tt", {24'd0, tt1}, 32'h96);
    chk("xor_mm", {28'd0, mm1}, 32'd1);
    chk("xor_ff", {29'd0, ff1}, 32'd0);
    chk("xor_pass", {31'd0, pass1}, 32'd0);

    // constant 0 against all ones: every entry fails
    run(0, 2, 8'hFF, 17, 1'b0, 1'b0);
    chk("c0_tt", {24'd0, tt1}, 32'h00);
    chk("c0_mm", {28'd0, mm1}, 32'd8);
    chk("c0_ff", {29'd0, ff1}, 32'd0);
    chk("c0_pass", {31'd0, pass1}, 32'd0);

    // mid-sweep start pulse and expected change are ignored
    run(0, 0, 8'h80, 17, 1'b0, 1'b1);
    chk("dist_pass", {31'd0, pass1}, 32'd1);
    chk("dist_mm", {28'd0, mm1}, 32'd0);
    chk("dist_tt", {24'd0, tt1}, 32'h80);

    // start held high: back-to-back sweeps
    @(negedge clk);
    expected = 8'h80;
    start1 = 1'b1;
    ndone = 0;
    dc[0] = -1; dc[1] = -1;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(negedge clk);
      if (cyc == 35) start1 = 1'b0;
      if (done1) begin
        if (ndone < 2) dc[ndone] = cyc;
        ndone++;
      end
    end
    chk("b2b_count", ndone, 32'd2);
    chk("b2b_first", dc[0], 32'd17);
    chk("b2b_second", dc[1], 32'd35);
    chk("b2b_idle", {31'd0, busy1}, 32'd0);
    chk("b2b_pass", {31'd0, pass1}, 32'd1);

    // reset at cycle 9 of an XOR sweep against all zeros
    @(negedge clk);
    mode1 = 1; expected = 8'h00; start1 = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      start1 = 1'b0;
    end
    chk("pre_rst_tt", {24'd0, tt1}, 32'h06);
    chk("pre_rst_mm", {28'd0, mm1}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy1}, 32'd0);
    chk("mid_rst_dut_x", {29'd0, dut_x1}, 32'd0);
    chk("mid_rst_tt", {24'd0, tt1}, 32'd0);
    chk("mid_rst_mm", {28'd0, mm1}, 32'd0);
    run(0, 0, 8'h80, 17, 1'b1, 1'b0);
    chk("post_rst_pass", {31'd0, pass1}, 32'd1);
    chk("post_rst_tt", {24'd0, tt1}, 32'h80);

    // reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1; start1 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start1 = 1'b0;
    @(negedge clk);
    chk("rst_over_start", {31'd0, busy1}, 32'd0);

    // delayed AND needs SETTLE=3; SETTLE=1 samples one vector late
    run(1, 3, 8'h80, 33, 1'b0, 1'b0);
    chk("dly3_pass", {31'd0, pass3}, 32'd1);
    chk("dly3_tt", {24'd0, tt3}, 32'h80);
    chk("dly3_mm", {28'd0, mm3}, 32'd0);
    run(0, 3, 8'h80, 17, 1'b0, 1'b0);
    chk("dly1_pass", {31'd0, pass1}, 32'd0);
    chk("dly1_mm", {28'd0, mm1}, 32'd1);
    chk("dly1_ff", {29'd0, ff1}, 32'd7);
    chk("dly1_tt", {24'd0, tt1}, 32'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
